// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, loads reset/interrupt vectors from imem.
// Optional stall/flush performance counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
    parameter int          ADDR_WIDTH        = 16,
    parameter int          RESET_VECTOR_ADDR = 0,
    parameter int          INT_VECTOR_ADDR   = 1,
    parameter logic [15:0] NOP_INSTR         = 16'h0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [15:0]           i_imem_data,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_interrupt,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [15:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_valid,
    output logic                  o_interrupt
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [15:0]           o_stall_count,
    output logic [15:0]           o_flush_count
`endif
);

    typedef enum logic [1:0] {
        S_RST_VEC = 2'd0,
        S_RUN     = 2'd1,
        S_INT_VEC = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(RESET_VECTOR_ADDR);
    localparam logic [ADDR_WIDTH-1:0] INT_ADDR = ADDR_WIDTH'(INT_VECTOR_ADDR);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  int_pending_reg, int_pending_next;
    logic [15:0]           instr_reg, instr_next;
    logic [ADDR_WIDTH-1:0] id_pc_reg, id_pc_next;
    logic                  valid_reg, valid_next;
    logic                  intr_reg, intr_next;
    logic [ADDR_WIDTH-1:0] vector_pc;

    // Vector words are instruction-width; fit them to the PC width.
    assign vector_pc = ADDR_WIDTH'(i_imem_data);

    always_comb begin
        o_imem_addr = pc_reg;
        case (state_reg)
            S_RST_VEC: o_imem_addr = RST_ADDR;
            S_INT_VEC: o_imem_addr = INT_ADDR;
            default:   o_imem_addr = pc_reg;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg       <= S_RST_VEC;
            pc_reg          <= '0;
            int_pending_reg <= 1'b0;
            instr_reg       <= NOP_INSTR;
            id_pc_reg       <= '0;
            valid_reg       <= 1'b0;
            intr_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            int_pending_reg <= int_pending_next;
            instr_reg       <= instr_next;
            id_pc_reg       <= id_pc_next;
            valid_reg       <= valid_next;
            intr_reg        <= intr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        int_pending_next = int_pending_reg | i_interrupt;
        instr_next       = instr_reg;
        id_pc_next       = id_pc_reg;
        valid_next       = valid_reg;
        intr_next        = intr_reg;
        case (state_reg)
            S_RST_VEC: begin
                pc_next    = vector_pc;
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
                intr_next  = 1'b0;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (i_branch_taken) begin
                    pc_next    = i_branch_target;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    intr_next  = 1'b0;
                end else if (i_stall) begin
                    pc_next = pc_reg;
                end else if (int_pending_reg || i_interrupt) begin
                    // The return address is the PC that was never fetched.
                    instr_next       = NOP_INSTR;
                    id_pc_next       = pc_reg;
                    valid_next       = 1'b0;
                    intr_next        = 1'b1;
                    int_pending_next = 1'b0;
                    state_next       = S_INT_VEC;
                end else begin
                    instr_next = i_imem_data;
                    id_pc_next = pc_reg;
                    valid_next = 1'b1;
                    intr_next  = 1'b0;
                    pc_next    = pc_reg + ADDR_WIDTH'(1);
                end
            end
            S_INT_VEC: begin
                if (i_branch_taken) begin
                    // Entry bubble is discarded, so take the interrupt again from the new PC.
                    pc_next          = i_branch_target;
                    instr_next       = NOP_INSTR;
                    valid_next       = 1'b0;
                    intr_next        = 1'b0;
                    int_pending_next = 1'b1;
                    state_next       = S_RUN;
                end else if (!i_stall) begin
                    pc_next    = vector_pc;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    intr_next  = 1'b0;
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_RST_VEC;
            end
        endcase
    end

    assign o_instr     = instr_reg;
    assign o_pc        = id_pc_reg;
    assign o_valid     = valid_reg;
    assign o_interrupt = intr_reg;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [1:0]  perf_inc;
    logic [15:0] perf_cnt_reg [2];

    // Index 0: stalled run cycles, index 1: accepted redirects.
    assign perf_inc[0] = (state_reg == S_RUN) && i_stall && !i_branch_taken;
    assign perf_inc[1] = ((state_reg == S_RUN) || (state_reg == S_INT_VEC)) && i_branch_taken;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_inc[gi] && (perf_cnt_reg[gi] != 16'hFFFF)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign o_stall_count = perf_cnt_reg[0];
    assign o_flush_count = perf_cnt_reg[1];
`endif

endmodule
